// File: rtl/busca_minas_input_ctrl.sv
// rtl/busca_minas_input_ctrl.sv - button sync/debounce, board cursor and command handshake
// Front end for busca_minas: four active-low buttons become cursor moves and reveal/flag commands.
module busca_minas_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BOARD_W         = 8,
  parameter int BOARD_H         = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mov_right,
  input  logic                       mov_down,
  input  logic                       sel,
  input  logic                       sel_flag,
  input  logic                       gameover,
  input  logic                       cmd_ready,
  output logic [$clog2(BOARD_W)-1:0] cur_x,
  output logic [$clog2(BOARD_H)-1:0] cur_y,
  output logic                       cmd_valid,
  output logic                       cmd_flag,
  output logic [$clog2(BOARD_W)-1:0] cmd_x,
  output logic [$clog2(BOARD_H)-1:0] cmd_y
);
  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {CMD_IDLE, CMD_PEND} cmd_state_t;

  // Bit order everywhere: 0 right, 1 down, 2 reveal, 3 flag.
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1, r_sync2, r_db, r_press;
  logic [3:0]    w_db_next, w_ev;
  logic [CW-1:0] r_cnt      [4];
  logic [CW-1:0] w_cnt_next [4];

  logic [XW-1:0] r_cur_x, r_cmd_x, w_cmd_x_next;
  logic [YW-1:0] r_cur_y, r_cmd_y, w_cmd_y_next;
  logic          r_cmd_flag, w_cmd_flag_next;
  cmd_state_t    r_state, w_state_next;

  assign w_raw = {sel_flag, sel, mov_down, mov_right};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_db_next[i]  = r_db[i];
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_db[i]) begin
        if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) w_db_next[i] = r_sync2[i];
        else                                      w_cnt_next[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Debounce keeps running during gameover so a held button never re-fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '1;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db    <= w_db_next;
      r_press <= r_db & ~w_db_next;
      for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  assign w_ev = r_press & {4{~gameover}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else begin
      if (w_ev[0]) r_cur_x <= (r_cur_x == XW'(BOARD_W - 1)) ? '0 : r_cur_x + XW'(1);
      if (w_ev[1]) r_cur_y <= (r_cur_y == YW'(BOARD_H - 1)) ? '0 : r_cur_y + YW'(1);
    end
  end

  // Command capture uses the pre-move cursor; reveal outranks flag in the same cycle.
  always_comb begin
    w_state_next    = r_state;
    w_cmd_flag_next = r_cmd_flag;
    w_cmd_x_next    = r_cmd_x;
    w_cmd_y_next    = r_cmd_y;
    case (r_state)
      CMD_IDLE: begin
        if (w_ev[2] || w_ev[3]) begin
          w_state_next    = CMD_PEND;
          w_cmd_flag_next = ~w_ev[2];
          w_cmd_x_next    = r_cur_x;
          w_cmd_y_next    = r_cur_y;
        end
      end
      CMD_PEND: begin
        if (gameover || cmd_ready) w_state_next = CMD_IDLE;
      end
      default: w_state_next = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= CMD_IDLE;
      r_cmd_flag <= 1'b0;
      r_cmd_x    <= '0;
      r_cmd_y    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cmd_flag <= w_cmd_flag_next;
      r_cmd_x    <= w_cmd_x_next;
      r_cmd_y    <= w_cmd_y_next;
    end
  end

  assign cur_x     = r_cur_x;
  assign cur_y     = r_cur_y;
  assign cmd_valid = (r_state == CMD_PEND);
  assign cmd_flag  = r_cmd_flag;
  assign cmd_x     = r_cmd_x;
  assign cmd_y     = r_cmd_y;
endmodule

// File: doc/busca_minas_input_ctrl.md
# busca_minas_input_ctrl

Front-end controller for the minesweeper game core. It turns the four raw active-low push buttons into clean commands: it synchronizes and debounces each button, detects presses, and keeps the board cursor with wrap-around. Reveal and flag requests are handed to the game core over a valid/ready handshake. It sits between the board pins and `busca_minas`, which consumes the cursor and the commands.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required to accept a level change (≥1).
- `BOARD_W`, default 8: board columns.
- `BOARD_H`, default 8: board rows.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mov_right`  in  1  raw button, active-low (0 = pressed), asynchronous to `clk`.
- `mov_down`  in  1  raw button, active-low, asynchronous.
- `sel`  in  1  raw reveal button, active-low, asynchronous.
- `sel_flag`  in  1  raw flag button, active-low, asynchronous.
- `gameover`  in  1  from core; 1 blocks all input activity.
- `cmd_ready`  in  1  core accepts the pending command.
- `cur_x`  out  $clog2(BOARD_W)  cursor column.
- `cur_y`  out  $clog2(BOARD_H)  cursor row.
- `cmd_valid`  out  1  command pending.
- `cmd_flag`  out  1  0 = reveal, 1 = flag toggle.
- `cmd_x`  out  $clog2(BOARD_W)  command column.
- `cmd_y`  out  $clog2(BOARD_H)  command row.

## Operation
- **Reset (`rst`=0).** All outputs are 0. Synchronizers and debounced states are set to 1 (released). Debounce counters are cleared and the command FSM is in CMD_IDLE. Reset asserted mid-debounce or mid-handshake aborts the operation immediately.
- **Synchronizer.** Each button passes through a 2-flop synchronizer.
- **Debounce, per button.**
  - A counter increments while the synchronized level differs from the debounced state.
  - The counter clears whenever the two are equal.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced state takes the new level and the counter clears.
- **Press event.** Generated on a debounced 1→0 transition: one cycle wide, registered. A release generates no event.
- **Move right.** `cur_x` ← (`cur_x` == `BOARD_W`-1) ? 0 : `cur_x`+1.
- **Move down.** `cur_y` ← (`cur_y` == `BOARD_H`-1) ? 0 : `cur_y`+1.
  - Right and down events in the same cycle are both applied.
- **Command FSM.**
  - CMD_IDLE: a sel event goes to CMD_PEND with `cmd_flag`=0. Otherwise a sel_flag event goes to CMD_PEND with `cmd_flag`=1.
  - When both events occur in the same cycle, reveal wins and the flag event is dropped.
  - On entry to CMD_PEND, `cmd_x`/`cmd_y` capture the cursor value *before* any move applied in the same cycle.
  - CMD_PEND: `cmd_valid`=1, and `cmd_flag`, `cmd_x`, `cmd_y` are held stable.
  - The transfer happens on a cycle with `cmd_valid` & `cmd_ready`; the FSM then returns to CMD_IDLE.
  - sel and sel_flag events arriving in CMD_PEND are dropped, with no queueing.
  - `cmd_ready` is ignored in CMD_IDLE.
- **gameover=1.**
  - Move and command events are discarded.
  - The FSM is forced to CMD_IDLE, so `cmd_valid` is 0 from the next edge.
  - The cursor is frozen.
  - Debouncing keeps running, so a button held across gameover deassertion does not produce a spurious press.

## Timing
- Counting the first edge that samples a stable raw low as edge 1:
  - the synchronized level is low after edge 2;
  - the debounced state falls at edge 2+`DEBOUNCE_CYCLES`;
  - the cursor or `cmd_valid` updates at edge 3+`DEBOUNCE_CYCLES`.
- Total press latency is `DEBOUNCE_CYCLES`+3 edges. With the default of 4, that is 7 edges.
- A raw low (or high) pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles is filtered, with no state change.
- A held button produces exactly one event. A new event requires a debounced release followed by a new press.
- Handshake:
  - `cmd_valid` falls on the edge after the accepting cycle.
  - A new command can assert at the earliest on the edge after `cmd_valid` falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, 8×8 board, 30-unit clock period.

1. **Reset.** Drive buttons high, `rst`=0 for 2 cycles, then release. Required: `cur_x`=0, `cur_y`=0, `cmd_valid`=0. Assert `rst`=0 for one cycle while `mov_right` is low mid-debounce: no cursor change after release.
2. **Right wrap.** Press `mov_right` 8 times, each low 10 cycles then high 10 cycles. Required: `cur_x` steps 1,2,…,7,0, `cur_y` stays 0, and each update occurs exactly 7 edges after the press is first sampled.
3. **Debounce.** Drive `mov_down` low for 3 cycles: `cur_y` unchanged. Then drive it low for 5 cycles: `cur_y` 0→1. Hold it low for 50 cycles: only one increment.
4. **Handshake.**
   - Move the cursor to (3,2), keep `cmd_ready`=0, and press `sel`. Required: `cmd_valid`=1, `cmd_x`=3, `cmd_y`=2, `cmd_flag`=0, held for 20 cycles.
   - Press `sel_flag` while the command is pending: it is dropped.
   - Pulse `cmd_ready`=1 for one cycle: `cmd_valid`=0 on the next edge, and no flag command follows.
5. **Simultaneous events.**
   - Release `sel` and `sel_flag` low on the same edge: exactly one command with `cmd_flag`=0.
   - At (7,7), press `mov_right` and `sel` simultaneously: `cmd_x`=7, `cmd_y`=7, and `cur_x` becomes 0.
6. **Gameover.** With a command pending, set `gameover`=1. Required: `cmd_valid`=0 on the next edge. Presses of all four buttons are ignored and the cursor is unchanged. After `gameover` returns to 0 with `sel` still held, no command is issued.
